// File: rtl/counter_share_arbiter.sv
// One CNT_W-bit up-counter time-shared between NUM_REQ requesters.
// A round-robin arbiter picks the owner, and the owner gets a done pulse when its run ends.
module counter_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic [NUM_REQ-1:0]       done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q,  busy_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   tgt_q,   tgt_d;
    logic [NUM_REQ-1:0] done_q,  done_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;

    logic [CNT_W-1:0]   len_slice [NUM_REQ];
    logic               found;
    logic [PTR_W-1:0]   win_idx;
    int                 idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
            assign len_slice[gi] = len[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Round-robin scan starting at ptr_q; the first asserted request wins.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        count_d = count_q;
        tgt_d   = tgt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                if (found) begin
                    state_d          = ST_RUN;
                    grant_d[win_idx] = 1'b1;
                    busy_d           = 1'b1;
                    tgt_d            = len_slice[win_idx];
                    owner_d          = win_idx;
                end
            end
            ST_RUN: begin
                if (count_q != tgt_q) begin
                    count_d = count_q + 1'b1;
                end else begin
                    // Run complete: pulse done to the owner and rotate priority past it.
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    done_d  = grant_q;
                    ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            tgt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: directed scenarios plus a per-cycle monitor that
// scoreboards each grant against the queued (owner, len) and checks the done latency.
module tb_counter_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*CNT_W-1:0] len = '0;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [CNT_W-1:0]         count;
    logic [NUM_REQ-1:0]       done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int exp_owner_q[$];
    int exp_len_q[$];

    logic rst_s = 1'b1;
    bit   run_active = 1'b0;
    int   run_owner = 0;
    int   run_len = 0;
    int   run_cnt = 0;
    logic [NUM_REQ-1:0] mon_oh;

    counter_share_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    // Monitor: invariants every cycle, plus scoreboard of grant order and done timing.
    always @(negedge clk) begin
        checks++;
        if (!(($countones(grant) <= 1) && (busy === |grant) && ($countones(done) <= 1)
              && !((|done) && busy))) begin
            errors++;
            $display("FAIL invariant cyc=%0d: grant=%b busy=%b done=%b", cyc, grant, busy, done);
        end
        if (rst_s) begin
            run_active = 1'b0;
        end else if (run_active) begin
            mon_oh = 4'b0001 << run_owner;
            checks++;
            if (run_cnt < run_len) begin
                run_cnt++;
                if (grant !== mon_oh || count !== 3'(run_cnt)) begin
                    errors++;
                    $display("FAIL run_step cyc=%0d: grant=%b count=%0d, required grant=%b count=%0d",
                             cyc, grant, count, mon_oh, run_cnt);
                end
            end else begin
                if (done !== mon_oh || grant !== 4'b0000 || count !== 3'd0) begin
                    errors++;
                    $display("FAIL done_latency cyc=%0d: done=%b grant=%b count=%0d, required done=%b grant=0000 count=0",
                             cyc, done, grant, count, mon_oh);
                end
                $display("txn owner=%0d len=%0d done at cycle %0d", run_owner, run_len, cyc);
                run_active = 1'b0;
            end
        end else if (grant !== 4'b0000) begin
            checks++;
            if (exp_owner_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant cyc=%0d: grant=%b, required no grant", cyc, grant);
            end else begin
                run_owner  = exp_owner_q.pop_front();
                run_len    = exp_len_q.pop_front();
                run_cnt    = 0;
                run_active = 1'b1;
                mon_oh     = 4'b0001 << run_owner;
                if (grant !== mon_oh || count !== 3'd0) begin
                    errors++;
                    $display("FAIL grant_order cyc=%0d: grant=%b count=%0d, required grant=%b count=0",
                             cyc, grant, count, mon_oh);
                end
            end
        end else begin
            checks++;
            if (done !== 4'b0000 || count !== 3'd0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d: done=%b count=%0d, required done=0000 count=0",
                         cyc, done, count);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || count !== 3'd0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b count=%0d done=%b, required all zero",
                     grant, busy, count, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single requester run: grant one cycle after req, count 0..l, done l+2 cycles after req.
    task automatic test_single(input int idx, input int l, input string name);
        logic [NUM_REQ-1:0] oh;
        oh = 4'b0001 << idx;
        exp_owner_q.push_back(idx);
        exp_len_q.push_back(l);
        len[idx*CNT_W +: CNT_W] = 3'(l);
        req[idx] = 1'b1;
        for (int k = 1; k <= l + 3; k++) begin
            @(negedge clk);
            checks++;
            if (k == 1) begin
                req[idx] = 1'b0;
                if (grant !== oh || busy !== 1'b1 || count !== 3'd0) begin
                    errors++;
                    $display("FAIL %s grant: grant=%b busy=%b count=%0d, required grant=%b busy=1 count=0",
                             name, grant, busy, count, oh);
                end
            end else if (k <= l + 1) begin
                if (grant !== oh || busy !== 1'b1 || count !== 3'(k - 1)) begin
                    errors++;
                    $display("FAIL %s count: grant=%b busy=%b count=%0d, required grant=%b busy=1 count=%0d",
                             name, grant, busy, count, oh, k - 1);
                end
            end else if (k == l + 2) begin
                if (done !== oh || grant !== 4'b0000 || busy !== 1'b0 || count !== 3'd0) begin
                    errors++;
                    $display("FAIL %s done: done=%b grant=%b busy=%b count=%0d, required done=%b idle",
                             name, done, grant, busy, count, oh);
                end
            end else begin
                if (done !== 4'b0000 || grant !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s after_done: done=%b grant=%b, required both zero",
                             name, done, grant);
                end
            end
        end
    endtask

    // ptr sits at 2 after requester 1 ran, so 3 must beat 1.
    task automatic test_rr_from_ptr();
        logic [NUM_REQ-1:0] prev;
        logic [NUM_REQ-1:0] order [2];
        int n_grant;
        int n_done;
        exp_owner_q.push_back(3); exp_len_q.push_back(1);
        exp_owner_q.push_back(1); exp_len_q.push_back(2);
        len[3*CNT_W +: CNT_W] = 3'd1;
        len[1*CNT_W +: CNT_W] = 3'd2;
        req = 4'b1010;
        prev = '0; n_grant = 0; n_done = 0;
        order[0] = '0; order[1] = '0;
        for (int k = 0; k < 30 && n_done < 2; k++) begin
            @(negedge clk);
            if (grant !== 4'b0000 && prev === 4'b0000) begin
                if (n_grant < 2) order[n_grant] = grant;
                n_grant++;
                req = req & ~grant;
            end
            if (done !== 4'b0000) n_done++;
            prev = grant;
        end
        checks++;
        if (n_done != 2 || order[0] !== 4'b1000 || order[1] !== 4'b0010) begin
            errors++;
            $display("FAIL rr_from_ptr: dones=%0d order=%b,%b, required dones=2 order=1000,0010",
                     n_done, order[0], order[1]);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        bit hit;
        exp_owner_q.push_back(1); exp_len_q.push_back(5);
        len[1*CNT_W +: CNT_W] = 3'd5;
        req[1] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 12 && !hit; k++) begin
            @(negedge clk);
            if (grant !== 4'b0000) req[1] = 1'b0;
            if (busy === 1'b1 && count === 3'd2) begin
                hit = 1'b1;
                rst = 1'b1;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_run timeout: count=2 never observed, last count=%0d", count);
        end
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || count !== 3'd0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_run state: grant=%b busy=%b count=%0d done=%b, required all zero",
                     grant, busy, count, done);
        end
        rst = 1'b0;
        @(negedge clk);
        test_single(3, 2, "rst_then_req3");
    endtask

    // All requesters held with len=1 from ptr=0: order 0,1,2,3,0, 2-cycle grants, 1-cycle gaps.
    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] prev;
        logic [NUM_REQ-1:0] exp_oh;
        int ord [5];
        int n_grant;
        int n_done;
        int dur;
        int gap;
        ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            exp_owner_q.push_back(ord[i]);
            exp_len_q.push_back(1);
        end
        len = {4{3'd1}};
        req = 4'b1111;
        prev = '0; n_grant = 0; n_done = 0; dur = 0; gap = 0;
        for (int k = 0; k < 40 && n_done < 5; k++) begin
            @(negedge clk);
            if (grant !== 4'b0000) begin
                if (prev === 4'b0000) begin
                    exp_oh = (n_grant < 5) ? (4'b0001 << ord[n_grant]) : 4'b0000;
                    checks++;
                    if (grant !== exp_oh || (n_grant > 0 && gap != 1)) begin
                        errors++;
                        $display("FAIL back_to_back grant %0d: grant=%b gap=%0d, required grant=%b gap=1",
                                 n_grant, grant, gap, exp_oh);
                    end
                    n_grant++;
                    dur = 0;
                    if (n_grant == 5) req = '0;
                end
                dur++;
            end else begin
                if (prev !== 4'b0000) begin
                    checks++;
                    if (dur != 2) begin
                        errors++;
                        $display("FAIL back_to_back duration: %0d cycles, required 2", dur);
                    end
                    n_done++;
                    gap = 0;
                end
                gap++;
            end
            prev = grant;
        end
        checks++;
        if (n_done != 5) begin
            errors++;
            $display("FAIL back_to_back timeout: %0d runs completed, required 5", n_done);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single(0, 3, "single_len3");
        test_single(2, 0, "single_len0");
        test_single(1, 7, "single_len7");
        test_rr_from_ptr();
        test_reset_mid_run();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_owner_q.size() != 0 || run_active) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected grants left, run_active=%0d, required 0 and 0",
                     exp_owner_q.size(), run_active);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
